// File: rtl/div_pkg.sv
// Shared definitions for the shift-subtract divider: default width, counter width
// and the command priority encoding used by the datapath, control and benches.
package div_pkg;

  parameter int unsigned DIV_WIDTH = 8;
  parameter int unsigned CNT_W     = $clog2(DIV_WIDTH);

  // Ordered by priority: a larger value wins when several commands are raised.
  typedef enum logic [1:0] {
    CmdNone  = 2'd0,
    CmdRight = 2'd1,
    CmdLeft  = 2'd2,
    CmdInit  = 2'd3
  } cmd_e;

  // Collapse the raw command strobes into the single command that takes effect.
  function automatic cmd_e decode_cmd(input logic init, input logic left, input logic right);
    if (init) begin
      return CmdInit;
    end else if (left) begin
      return CmdLeft;
    end else if (right) begin
      return CmdRight;
    end
    return CmdNone;
  endfunction

endpackage

// File: rtl/divide_datapath_if.sv
// Command/status bundle between the divider controller and its datapath.
interface divide_datapath_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             init;
  logic             left;
  logic             right;
  logic             sub;
  logic             cnt_is_0;
  logic             divisor_is_0;
  logic             dvsr_less_than_dvnd;
  logic             shifted_divisor_MSB;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  // Controller side: issues commands and operands, branches on the flags.
  modport master (
    output dividend, divisor, init, left, right, sub,
    input  cnt_is_0, divisor_is_0, dvsr_less_than_dvnd, shifted_divisor_MSB,
    input  quotient, remainder
  );

  // Datapath side.
  modport slave (
    input  dividend, divisor, init, left, right, sub,
    output cnt_is_0, divisor_is_0, dvsr_less_than_dvnd, shifted_divisor_MSB,
    output quotient, remainder
  );

endinterface

// File: rtl/div_shift_counter.sv
// Saturating up/down counter tracking how far the divisor has been normalised.
module div_shift_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             is_zero_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Next count: clear wins, then increment, then decrement; both ends saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end else if (dec_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/divide_datapath.sv
// Datapath of the shift-subtract divider: remainder, divisor, quotient and shift
// count registers plus the combinational status flags the controller branches on.
module divide_datapath
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic               clk,
  input logic               reset,
  divide_datapath_if.slave  bus
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_d, rem_q;
  logic [WIDTH-1:0] dvsr_d, dvsr_q;
  logic [WIDTH-1:0] quo_d, quo_q;
  logic             cnt_clr, cnt_inc, cnt_dec;
  logic [CntW-1:0]  cnt;
  logic             cnt_zero;
  cmd_e             cmd;

  assign cmd = decode_cmd(bus.init, bus.left, bus.right);

  // Next-state for the data registers and counter controls from the winning command.
  always_comb begin
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    quo_d   = quo_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    unique case (cmd)
      CmdInit: begin
        rem_d   = bus.dividend;
        dvsr_d  = bus.divisor;
        quo_d   = '0;
        cnt_clr = 1'b1;
      end
      CmdLeft: begin
        // Stop once the MSB is set so the divisor can never overflow.
        if (!dvsr_q[WIDTH-1]) begin
          dvsr_d  = dvsr_q << 1;
          cnt_inc = 1'b1;
        end
      end
      CmdRight: begin
        quo_d = {quo_q[WIDTH-2:0], bus.sub};
        // Wraps modulo 2^WIDTH if the controller subtracts when it should not.
        if (bus.sub) rem_d = rem_q - dvsr_q;
        dvsr_d  = dvsr_q >> 1;
        cnt_dec = 1'b1;
      end
      default: ;
    endcase
  end

  // Data registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      dvsr_q <= '0;
      quo_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
      quo_q  <= quo_d;
    end
  end

  div_shift_counter #(
    .CNT_W (CntW)
  ) u_cnt (
    .clk_i     (clk),
    .rst_i     (reset),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_inc),
    .dec_i     (cnt_dec),
    .cnt_o     (cnt),
    .is_zero_o (cnt_zero)
  );

  logic unused_cnt;
  assign unused_cnt = ^cnt;

  assign bus.cnt_is_0            = cnt_zero;
  assign bus.divisor_is_0        = (dvsr_q == '0);
  assign bus.dvsr_less_than_dvnd = (dvsr_q <= rem_q);
  assign bus.shifted_divisor_MSB = dvsr_q[WIDTH-1];
  assign bus.quotient            = quo_q;
  assign bus.remainder           = rem_q;

endmodule

// File: tb/tb_divide_datapath.sv
// Directed bench for divide_datapath at WIDTH=8.
module tb_divide_datapath;
  import div_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  divide_datapath_if #(.WIDTH(8)) bus ();

  divide_datapath #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.init  = 1'b0;
    bus.left  = 1'b0;
    bus.right = 1'b0;
    bus.sub   = 1'b0;
  endtask

  task automatic do_init(input logic [7:0] dvnd, input logic [7:0] dvsr);
    idle();
    bus.dividend = dvnd;
    bus.divisor  = dvsr;
    bus.init     = 1'b1;
    step();
    idle();
    bus.dividend = 8'hA5;  // operands are don't-care outside init
    bus.divisor  = 8'h5A;
  endtask

  task automatic do_left();
    idle();
    bus.left = 1'b1;
    step();
    idle();
  endtask

  task automatic do_right(input logic s);
    idle();
    bus.right = 1'b1;
    bus.sub   = s;
    step();
    idle();
  endtask

  task automatic test_reset();
    // Power-on reset values
    checks++;
    if ({bus.cnt_is_0, bus.divisor_is_0, bus.dvsr_less_than_dvnd, bus.shifted_divisor_MSB}
        !== 4'b1110) begin
      errors++;
      $display("FAIL reset_flags got %b want 1110", {bus.cnt_is_0, bus.divisor_is_0,
               bus.dvsr_less_than_dvnd, bus.shifted_divisor_MSB});
    end
    reset = 1'b0;
    step();
    // Load arbitrary state, then reset mid-cycle
    do_init(8'd200, 8'd3);
    do_left();
    do_left();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.cnt_is_0, bus.divisor_is_0, bus.dvsr_less_than_dvnd, bus.shifted_divisor_MSB}
        !== 4'b1110) begin
      errors++;
      $display("FAIL midreset_flags got %b want 1110", {bus.cnt_is_0, bus.divisor_is_0,
               bus.dvsr_less_than_dvnd, bus.shifted_divisor_MSB});
    end
    checks++;
    if (bus.quotient !== 8'd0 || bus.remainder !== 8'd0) begin
      errors++;
      $display("FAIL midreset_qr got q=%0d r=%0d want 0 0", bus.quotient, bus.remainder);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_100_by_7();
    logic [5:0] bits;
    bits = 6'b001110;  // MSB first: 0,0,1,1,1,0
    do_init(8'd100, 8'd7);
    checks++;
    if (bus.remainder !== 8'd100 || bus.quotient !== 8'd0 || bus.cnt_is_0 !== 1'b1) begin
      errors++;
      $display("FAIL init_100_7 got r=%0d q=%0d c0=%b want 100 0 1",
               bus.remainder, bus.quotient, bus.cnt_is_0);
    end
    for (int i = 0; i < 4; i++) do_left();
    checks++;
    if (dut.dvsr_q !== 8'd112 || bus.shifted_divisor_MSB !== 1'b0) begin
      errors++;
      $display("FAIL left4_7 got dvsr=%0d msb=%b want 112 0", dut.dvsr_q,
               bus.shifted_divisor_MSB);
    end
    do_left();
    checks++;
    if (dut.dvsr_q !== 8'd224 || bus.shifted_divisor_MSB !== 1'b1 || bus.cnt_is_0 !== 1'b0) begin
      errors++;
      $display("FAIL left5_7 got dvsr=%0d msb=%b c0=%b want 224 1 0", dut.dvsr_q,
               bus.shifted_divisor_MSB, bus.cnt_is_0);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.dvsr_less_than_dvnd !== bits[5-i]) begin
        errors++;
        $display("FAIL flag_100_7[%0d] got %b want %b", i, bus.dvsr_less_than_dvnd, bits[5-i]);
      end
      checks++;
      if (bus.cnt_is_0 !== (i == 5)) begin
        errors++;
        $display("FAIL cnt0_100_7[%0d] got %b want %b", i, bus.cnt_is_0, (i == 5));
      end
      do_right(bits[5-i]);
    end
    checks++;
    if (bus.quotient !== 8'd14 || bus.remainder !== 8'd2 || bus.cnt_is_0 !== 1'b1) begin
      errors++;
      $display("FAIL result_100_7 got q=%0d r=%0d c0=%b want 14 2 1",
               bus.quotient, bus.remainder, bus.cnt_is_0);
    end
    // Result holds while idle
    step();
    step();
    checks++;
    if (bus.quotient !== 8'd14 || bus.remainder !== 8'd2) begin
      errors++;
      $display("FAIL hold_100_7 got q=%0d r=%0d want 14 2", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_3_by_5();
    do_init(8'd3, 8'd5);
    for (int i = 0; i < 5; i++) do_left();
    checks++;
    if (dut.dvsr_q !== 8'd160 || bus.shifted_divisor_MSB !== 1'b1) begin
      errors++;
      $display("FAIL left_3_5 got dvsr=%0d msb=%b want 160 1", dut.dvsr_q,
               bus.shifted_divisor_MSB);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (bus.dvsr_less_than_dvnd !== 1'b0) begin
        errors++;
        $display("FAIL flag_3_5[%0d] got %b want 0", i, bus.dvsr_less_than_dvnd);
      end
      do_right(1'b0);
    end
    checks++;
    if (bus.quotient !== 8'd0 || bus.remainder !== 8'd3 || bus.cnt_is_0 !== 1'b1) begin
      errors++;
      $display("FAIL result_3_5 got q=%0d r=%0d c0=%b want 0 3 1",
               bus.quotient, bus.remainder, bus.cnt_is_0);
    end
  endtask

  task automatic test_div_zero();
    do_init(8'd42, 8'd0);
    checks++;
    if (bus.divisor_is_0 !== 1'b1 || bus.dvsr_less_than_dvnd !== 1'b1 ||
        bus.remainder !== 8'd42) begin
      errors++;
      $display("FAIL div_zero got d0=%b le=%b r=%0d want 1 1 42", bus.divisor_is_0,
               bus.dvsr_less_than_dvnd, bus.remainder);
    end
  endtask

  task automatic test_left_guard();
    do_init(8'd55, 8'h80);
    checks++;
    if (bus.shifted_divisor_MSB !== 1'b1 || bus.divisor_is_0 !== 1'b0) begin
      errors++;
      $display("FAIL guard_init got msb=%b d0=%b want 1 0", bus.shifted_divisor_MSB,
               bus.divisor_is_0);
    end
    do_left();
    checks++;
    if (dut.dvsr_q !== 8'h80 || bus.cnt_is_0 !== 1'b1) begin
      errors++;
      $display("FAIL guard_left got dvsr=%h c0=%b want 80 1", dut.dvsr_q, bus.cnt_is_0);
    end
  endtask

  task automatic test_priority();
    do_init(8'd9, 8'd4);
    // left beats right (right with sub would have subtracted)
    idle();
    bus.left  = 1'b1;
    bus.right = 1'b1;
    bus.sub   = 1'b1;
    step();
    idle();
    checks++;
    if (dut.dvsr_q !== 8'd8 || bus.remainder !== 8'd9 || bus.quotient !== 8'd0 ||
        bus.cnt_is_0 !== 1'b0) begin
      errors++;
      $display("FAIL prio_left got dvsr=%0d r=%0d q=%0d c0=%b want 8 9 0 0", dut.dvsr_q,
               bus.remainder, bus.quotient, bus.cnt_is_0);
    end
    // init beats everything
    bus.dividend = 8'd200;
    bus.divisor  = 8'd3;
    bus.init     = 1'b1;
    bus.left     = 1'b1;
    bus.right    = 1'b1;
    bus.sub      = 1'b1;
    step();
    idle();
    checks++;
    if (dut.dvsr_q !== 8'd3 || bus.remainder !== 8'd200 || bus.quotient !== 8'd0 ||
        bus.cnt_is_0 !== 1'b1) begin
      errors++;
      $display("FAIL prio_init got dvsr=%0d r=%0d q=%0d c0=%b want 3 200 0 1", dut.dvsr_q,
               bus.remainder, bus.quotient, bus.cnt_is_0);
    end
    // sub alone does nothing
    do_init(8'd9, 8'd4);
    bus.sub = 1'b1;
    step();
    idle();
    checks++;
    if (bus.remainder !== 8'd9 || bus.quotient !== 8'd0 || dut.dvsr_q !== 8'd4) begin
      errors++;
      $display("FAIL sub_alone got r=%0d q=%0d dvsr=%0d want 9 0 4", bus.remainder,
               bus.quotient, dut.dvsr_q);
    end
    // right at count 0: subtracts, shifts, count saturates at 0
    do_right(1'b1);
    checks++;
    if (bus.remainder !== 8'd5 || bus.quotient !== 8'd1 || dut.dvsr_q !== 8'd2 ||
        bus.cnt_is_0 !== 1'b1) begin
      errors++;
      $display("FAIL right_sat got r=%0d q=%0d dvsr=%0d c0=%b want 5 1 2 1", bus.remainder,
               bus.quotient, dut.dvsr_q, bus.cnt_is_0);
    end
    // faulty subtract wraps modulo 256: 5-2=3, then 3-1=2, then 2-0=2 ... use 3-? below
    do_init(8'd3, 8'd5);
    do_right(1'b1);
    checks++;
    if (bus.remainder !== 8'd254 || bus.quotient !== 8'd1) begin
      errors++;
      $display("FAIL wrap_sub got r=%0d q=%0d want 254 1", bus.remainder, bus.quotient);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.dividend = '0;
    bus.divisor  = '0;
    idle();
    #2;
    test_reset();
    test_100_by_7();
    test_3_by_5();
    test_div_zero();
    test_left_guard();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divide_datapath.md
# divide_datapath

Datapath half of the shift-subtract divider. It holds the remainder, divisor, quotient and shift-count registers, and executes the `init`/`left`/`right`/`sub` commands issued by `control`. It returns the status flags `control` branches on: `cnt_is_0`, `divisor_is_0`, `dvsr_less_than_dvnd` and `shifted_divisor_MSB`. The top-level divider instantiates `control` and `divide_datapath` side by side and connects the like-named signals.

## Interface
- `WIDTH`, 8: operand, quotient and remainder width; must be 2 or more.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `dividend` input WIDTH: sampled only on `init`.
- `divisor` input WIDTH: sampled only on `init`.
- `init` input 1: load operands.
- `left` input 1: normalise the divisor by one shift left.
- `right` input 1: produce one quotient bit.
- `sub` input 1: the bit being produced by `right` is 1.
- `cnt_is_0` output 1: shift count equals 0.
- `divisor_is_0` output 1: divisor register equals 0.
- `dvsr_less_than_dvnd` output 1: divisor register ≤ remainder register (unsigned compare, equality included).
- `shifted_divisor_MSB` output 1: divisor register bit WIDTH-1.
- `quotient` output WIDTH: quotient register.
- `remainder` output WIDTH: remainder register.

## Operation
- Registers:
  - `rem_r`, `dvsr_r`, `quo_r`: WIDTH bits each.
  - `cnt_r`: clog2(WIDTH) bits, range 0..WIDTH-1.
- Status flags are pure combinational decodes of the registers, with no extra flops.
- Command priority per edge: `init` > `left` > `right`. Lower-priority commands asserted in the same cycle are ignored.
- `init`:
  - `rem_r`←`dividend`, `dvsr_r`←`divisor`.
  - `quo_r`←0, `cnt_r`←0.
- `left`:
  - If `dvsr_r`[WIDTH-1]=0: `dvsr_r`←`dvsr_r`<<1, `cnt_r`←`cnt_r`+1.
  - If the MSB is already 1, the command is ignored; this guard prevents overflow.
  - `cnt_r` therefore never exceeds WIDTH-1.
- `right` (one quotient bit):
  - `quo_r`←{`quo_r`[WIDTH-2:0], `sub`}.
  - If `sub`=1: `rem_r`←`rem_r`−`dvsr_r`.
  - `dvsr_r`←`dvsr_r`>>1 (zero fill).
  - `cnt_r`←`cnt_r`−1, saturating at 0.
  - Subtraction uses the pre-edge `dvsr_r`.
- `sub` without `right`: no effect.
- `sub`=1 while `dvsr_less_than_dvnd`=0 is a controller fault. The datapath still subtracts, modulo 2^WIDTH, and performs no checking.
- Protocol contract with `control`:
  - `init` once.
  - `left` until `shifted_divisor_MSB`=1.
  - `right` asserted `cnt_r`+1 times, with `sub`=`dvsr_less_than_dvnd` each cycle. The final `right` is issued while `cnt_is_0`=1.
  - After that, `quotient`/`remainder` hold the result until the next `init`.
- Divisor 0:
  - `divisor_is_0`=1 the cycle after `init`; `control` then goes to ERROR.
  - `left` on zero shifts zero and increments `cnt_r`; this is harmless, and the values are don't-care.

## Timing
- Reset, asynchronous and immediate: all registers 0. Resulting outputs:
  - `cnt_is_0`=1, `divisor_is_0`=1, `dvsr_less_than_dvnd`=1, `shifted_divisor_MSB`=0.
  - `quotient`=0, `remainder`=0.
- Commands sampled at rising `clk`. Register updates and the flags derived from them are visible after that edge, ready for `control` to sample at the next edge.
- Latency for WIDTH=8, excluding the `control` states:
  - 1 `init` cycle.
  - k `left` cycles, k ≤ 7.
  - k+1 `right` cycles.
  - Worst case 16 cycles.
- Reset mid-operation: all state cleared within the same cycle; a pending command is lost.
- Inputs `dividend`/`divisor` may change freely except in the `init` cycle.

## Structure
- Shared package `div_pkg`:
  - `DIV_WIDTH` default constant.
  - `CNT_W = $clog2(DIV_WIDTH)`.
  - Command priority enum, shared with `control` and the benches.
- One natural sub-module, `div_shift_counter`: saturating up/down counter with load-zero and `is_zero` output, parameterised by `CNT_W`.
- Compare, subtract and shifts stay inline in `divide_datapath`.

## Test plan
- Reset: assert `reset` mid-cycle with arbitrary registers. Required immediately: all outputs at reset values (1,1,1,0, quotient 0, remainder 0).
- 100/7, WIDTH=8:
  - `init`.
  - 5×`left`: `dvsr_r` goes 7→224; `shifted_divisor_MSB`=1; `cnt_r`=5.
  - 6×`right`, each with `sub`=flag: quotient bits 0,0,1,1,1,0.
  - Required result: `quotient`=14, `remainder`=2, `cnt_is_0`=1.
- 3/5:
  - `init`, 5×`left` (`dvsr_r`=160), 6×`right` with every `sub`=0.
  - Required result: `quotient`=0, `remainder`=3.
- Divide by zero: `init` 42/0. Required: `divisor_is_0`=1 on the next cycle and `dvsr_less_than_dvnd`=1.
- Left guard: `init` x/0x80, then `left`. Required: `dvsr_r` stays 0x80 and `cnt_is_0` stays 1.
- Priority:
  - `init`+`left`+`right` in the same cycle: only `init` takes effect.
  - `sub` alone with `rem_r`=9, `dvsr_r`=4: `rem_r` stays 9 and `quo_r` is unchanged.
